// File: rtl/alu_stage_ctrl_if.sv
// Panel/ALU bus bundle for the ALU stage controller.
interface alu_stage_ctrl_if;
  localparam int unsigned DW = 16;

  logic          next_pulse;
  logic          back_pulse;
  logic          chain_pulse;
  logic [DW-1:0] sw;
  logic [DW-1:0] alu_result;
  logic          alu_status;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [1:0]    opcode;
  logic [1:0]    state;
  logic [DW-1:0] result_q;
  logic          err;
  logic          led_r;
  logic          led_g;

  // Controller side.
  modport slave (
    input  next_pulse, back_pulse, chain_pulse, sw, alu_result, alu_status,
    output op1, op2, opcode, state, result_q, err, led_r, led_g
  );

  // Panel/ALU side.
  modport master (
    output next_pulse, back_pulse, chain_pulse, sw, alu_result, alu_status,
    input  op1, op2, opcode, state, result_q, err, led_r, led_g
  );
endinterface

// File: rtl/alu_stage_ctrl.sv
// Operand/opcode entry sequencer for a switch-driven ALU: OP1 -> OP2 -> OPC -> RES.
// Optional feature macro: ALU_CHAIN_EN (chain_pulse in RES feeds result_q back into op1).
module alu_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic           CLK100MHZ,
  input  logic           CPU_RESETN,
  alu_stage_ctrl_if.slave bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_OP1 = 2'd0,
    S_OP2 = 2'd1,
    S_OPC = 2'd2,
    S_RES = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;
  logic [1:0]    opc_q, opc_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic          first_q, first_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          armed_q;

  logic [1:0]    req_cnt;
  logic          req_vld;
  logic          do_next;
  logic          do_back;
`ifdef ALU_CHAIN_EN
  logic          do_chain;
`endif
  logic          to_hit;

  // Qualify requests: exactly one pulse high, never on the first edge after reset release.
  always_comb begin
    req_cnt = 2'(bus.next_pulse) + 2'(bus.back_pulse) + 2'(bus.chain_pulse);
    req_vld = armed_q && (req_cnt == 2'd1);
    do_next = req_vld && bus.next_pulse;
    do_back = req_vld && bus.back_pulse;
`ifdef ALU_CHAIN_EN
    do_chain = req_vld && bus.chain_pulse;
`endif
    to_hit  = TO_EN && (idle_q == TO_LAST);
  end

  // Next-state, register loads, result capture and inactivity counting.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    res_d   = res_q;
    err_d   = err_q;

    // ALU inputs settle during the first RES cycle; capture at its end.
    if (state_q == S_RES && first_q) begin
      res_d = bus.alu_result;
      err_d = bus.alu_status;
    end

    case (state_q)
      S_OP1: begin
        if (do_next) begin
          op1_d   = bus.sw;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        if (do_next) begin
          op2_d   = bus.sw;
          state_d = S_OPC;
        end else if (do_back) begin
          state_d = S_OP1;
        end
      end
      S_OPC: begin
        if (do_next) begin
          opc_d   = bus.sw[1:0];
          state_d = S_RES;
        end else if (do_back) begin
          state_d = S_OP2;
        end
      end
      S_RES: begin
        if (do_next) begin
          err_d   = 1'b0;
          state_d = S_OP1;
        end else if (do_back) begin
          err_d   = 1'b0;
          state_d = S_OPC;
`ifdef ALU_CHAIN_EN
        end else if (do_chain) begin
          op1_d   = res_q;
          err_d   = 1'b0;
          state_d = S_OP2;
`endif
        end else if (to_hit) begin
          err_d   = 1'b0;
          state_d = S_OP1;
        end
      end
      default: state_d = S_OP1;
    endcase

    first_d = (state_d == S_RES) && (state_q != S_RES);
    idle_d  = (state_q == S_RES && state_d == S_RES && !req_vld) ? idle_q + CW'(1) : '0;
  end

  // State and datapath registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= S_OP1;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      idle_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      res_q   <= res_d;
      err_q   <= err_d;
      first_q <= first_d;
      idle_q  <= idle_d;
      armed_q <= 1'b1;
    end
  end

  assign bus.op1      = op1_q;
  assign bus.op2      = op2_q;
  assign bus.opcode   = opc_q;
  assign bus.state    = state_q;
  assign bus.result_q = res_q;
  assign bus.err      = err_q;
  assign bus.led_g    = (state_q == S_RES) && !err_q;
  assign bus.led_r    = (state_q == S_RES) && err_q;
endmodule

// File: tb/tb_alu_stage_ctrl.sv
// Scoreboard bench for alu_stage_ctrl: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_alu_stage_ctrl;
  localparam int unsigned TO = 10;
  localparam int F_STATE = 0, F_OP1 = 1, F_OP2 = 2, F_OPC = 3,
                 F_RES = 4, F_ERR = 5, F_LEDR = 6, F_LEDG = 7;

  typedef struct {
    int          cyc;
    int          step;
    int          sel;
    logic [15:0] exp;
  } chk_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic alu_err = 1'b0;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   step    = 0;
  chk_t sb[$];

  alu_stage_ctrl_if bus();

  alu_stage_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or.
  always_comb begin
    case (bus.opcode)
      2'd0:    bus.alu_result = bus.op1 + bus.op2;
      2'd1:    bus.alu_result = bus.op1 - bus.op2;
      2'd2:    bus.alu_result = bus.op1 & bus.op2;
      default: bus.alu_result = bus.op1 | bus.op2;
    endcase
  end
  assign bus.alu_status = alu_err;

  function automatic logic [15:0] peek(input int sel);
    case (sel)
      F_STATE: return 16'(bus.state);
      F_OP1:   return bus.op1;
      F_OP2:   return bus.op2;
      F_OPC:   return 16'(bus.opcode);
      F_RES:   return bus.result_q;
      F_ERR:   return 16'(bus.err);
      F_LEDR:  return 16'(bus.led_r);
      default: return 16'(bus.led_g);
    endcase
  endfunction

  function automatic string fname(input int sel);
    case (sel)
      F_STATE: return "state";
      F_OP1:   return "op1";
      F_OP2:   return "op2";
      F_OPC:   return "opcode";
      F_RES:   return "result_q";
      F_ERR:   return "err";
      F_LEDR:  return "led_r";
      default: return "led_g";
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pulse pattern for one edge, then drop it.
  task automatic press(input logic n, input logic b, input logic c, input logic [15:0] v);
    bus.sw          = v;
    bus.next_pulse  = n;
    bus.back_pulse  = b;
    bus.chain_pulse = c;
    tick();
    bus.next_pulse  = 1'b0;
    bus.back_pulse  = 1'b0;
    bus.chain_pulse = 1'b0;
  endtask

  // Queue an expectation for the negedge that follows edge (cyc + dly).
  task automatic expect_at(input int dly, input int sel, input logic [15:0] v);
    chk_t c;
    c.cyc  = cyc + dly;
    c.step = step;
    c.sel  = sel;
    c.exp  = v;
    sb.push_back(c);
  endtask

  task automatic expect_all_zero();
    for (int s = F_STATE; s <= F_LEDG; s++) expect_at(0, s, 16'h0000);
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_chk = n_chk + 1;
        if (sb[i].cyc < cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL step%0d %s: check missed (due cycle %0d, now %0d)",
                   sb[i].step, fname(sb[i].sel), sb[i].cyc, cyc);
        end else if (peek(sb[i].sel) !== sb[i].exp) begin
          n_fail = n_fail + 1;
          $display("FAIL step%0d %s: got 0x%04h, expected 0x%04h (cycle %0d)",
                   sb[i].step, fname(sb[i].sel), peek(sb[i].sel), sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sw          = '0;
    bus.next_pulse  = 1'b0;
    bus.back_pulse  = 1'b0;
    bus.chain_pulse = 1'b0;

    // Reset values.
    step = 1;
    repeat (2) tick();
    expect_all_zero();
    tick();

    // Pulse coincident with reset release is ignored.
    step = 2;
    @(negedge clk);
    bus.next_pulse = 1'b1;
    bus.sw         = 16'h1234;
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    bus.next_pulse = 1'b0;
    expect_at(0, F_STATE, 16'd0);
    expect_at(0, F_OP1,   16'h0000);
    tick();
    expect_at(0, F_STATE, 16'd0);

    // 5 + 3 with add; sw wiggle between loads has no effect.
    step = 3;
    press(1'b1, 1'b0, 1'b0, 16'h0005);
    expect_at(0, F_STATE, 16'd1);
    expect_at(0, F_OP1,   16'h0005);
    bus.sw = 16'hFFFF;
    repeat (2) tick();
    expect_at(0, F_OP1,   16'h0005);
    expect_at(0, F_STATE, 16'd1);
    press(1'b1, 1'b0, 1'b0, 16'h0003);
    expect_at(0, F_STATE, 16'd2);
    expect_at(0, F_OP2,   16'h0003);
    press(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(0, F_STATE, 16'd3);
    expect_at(0, F_OPC,   16'd0);
    expect_at(0, F_RES,   16'h0000);
    expect_at(1, F_RES,   16'h0008);
    expect_at(1, F_LEDG,  16'd1);
    expect_at(1, F_LEDR,  16'd0);
    expect_at(1, F_ERR,   16'd0);
    repeat (2) tick();
    press(1'b1, 1'b0, 1'b0, 16'hFFFF);
    expect_at(0, F_STATE, 16'd0);
    expect_at(0, F_OP1,   16'h0005);
    expect_at(0, F_OP2,   16'h0003);
    expect_at(0, F_RES,   16'h0008);
    expect_at(0, F_LEDG,  16'd0);

    // Simultaneous pulses do nothing; back steps, back in OP1 is ignored.
    step = 4;
    press(1'b1, 1'b0, 1'b0, 16'h0007);
    expect_at(0, F_STATE, 16'd1);
    expect_at(0, F_OP1,   16'h0007);
    press(1'b1, 1'b1, 1'b0, 16'h0009);
    expect_at(0, F_STATE, 16'd1);
    expect_at(0, F_OP2,   16'h0003);
    press(1'b1, 1'b0, 1'b1, 16'h0009);
    expect_at(0, F_STATE, 16'd1);
    expect_at(0, F_OP2,   16'h0003);
    press(1'b0, 1'b1, 1'b0, 16'h0009);
    expect_at(0, F_STATE, 16'd0);
    expect_at(0, F_OP1,   16'h0007);
    press(1'b0, 1'b1, 1'b0, 16'h0000);
    expect_at(0, F_STATE, 16'd0);

    // Error capture (10 - 4 = 6 with status high), then back clears it.
    step = 5;
    press(1'b1, 1'b0, 1'b0, 16'h000A);
    press(1'b1, 1'b0, 1'b0, 16'h0004);
    alu_err = 1'b1;
    press(1'b1, 1'b0, 1'b0, 16'h0001);
    expect_at(1, F_RES,  16'h0006);
    expect_at(1, F_ERR,  16'd1);
    expect_at(1, F_LEDR, 16'd1);
    expect_at(1, F_LEDG, 16'd0);
    tick();
    alu_err = 1'b0;
    tick();
    expect_at(0, F_ERR,  16'd1);
    press(1'b0, 1'b1, 1'b0, 16'h0000);
    expect_at(0, F_STATE, 16'd2);
    expect_at(0, F_ERR,   16'd0);
    expect_at(0, F_LEDR,  16'd0);
    expect_at(0, F_LEDG,  16'd0);
    expect_at(0, F_RES,   16'h0006);

    // Idle timeout: 10 + 4 = 0xE, back to OP1 exactly 10 cycles after RES entry.
    step = 6;
    press(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(1,  F_RES,   16'h000E);
    expect_at(9,  F_STATE, 16'd3);
    expect_at(10, F_STATE, 16'd0);
    expect_at(10, F_OP1,   16'h000A);
    expect_at(10, F_OP2,   16'h0004);
    expect_at(10, F_ERR,   16'd0);
    repeat (10) tick();

    // A request in the timeout cycle wins over the timeout.
    step = 7;
    press(1'b1, 1'b0, 1'b0, 16'h0005);
    press(1'b1, 1'b0, 1'b0, 16'h0003);
    press(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (9) tick();
    press(1'b0, 1'b1, 1'b0, 16'h0000);
    expect_at(0, F_STATE, 16'd2);
    press(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(0, F_STATE, 16'd3);
    expect_at(1, F_RES,   16'h0008);

    // Chain request in RES with result 8.
    step = 8;
    repeat (4) tick();
    press(1'b0, 1'b0, 1'b1, 16'h0000);
`ifdef ALU_CHAIN_EN
    expect_at(0, F_STATE, 16'd1);
    expect_at(0, F_OP1,   16'h0008);
    expect_at(0, F_ERR,   16'd0);
    press(1'b0, 1'b1, 1'b0, 16'h0000);
    expect_at(0, F_STATE, 16'd0);
`else
    expect_at(0,  F_STATE, 16'd3);
    expect_at(0,  F_OP1,   16'h0005);
    expect_at(9,  F_STATE, 16'd3);
    expect_at(10, F_STATE, 16'd0);
    repeat (10) tick();
`endif

    // Next late in the idle window returns to OP1 at once.
    step = 9;
    press(1'b1, 1'b0, 1'b0, 16'h0005);
    press(1'b1, 1'b0, 1'b0, 16'h0003);
    press(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (8) tick();
    expect_at(0, F_STATE, 16'd3);
    press(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(0, F_STATE, 16'd0);
    expect_at(0, F_RES,   16'h0008);

    // Asynchronous reset while in OPC, then a fresh entry loads op1.
    step = 10;
    press(1'b1, 1'b0, 1'b0, 16'h0005);
    press(1'b1, 1'b0, 1'b0, 16'h0003);
    expect_at(0, F_STATE, 16'd2);
    tick();
    rst_n = 1'b0;
    expect_all_zero();
    repeat (2) tick();
    rst_n = 1'b1;
    press(1'b1, 1'b0, 1'b0, 16'h0021);
    expect_at(0, F_STATE, 16'd0);
    expect_at(0, F_OP1,   16'h0000);
    press(1'b1, 1'b0, 1'b0, 16'h0021);
    expect_at(0, F_STATE, 16'd1);
    expect_at(0, F_OP1,   16'h0021);

    repeat (12) tick();
    while (sb.size() != 0) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL step%0d %s: expectation never evaluated", sb[0].step, fname(sb[0].sel));
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_stage_ctrl.md
ALU_STAGE_CTRL -- requirements
Module: alu_stage_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 1_000_000_000, cycles of inactivity in S_RES before automatic return to S_OP1 (0 = timeout disabled).
REQ-002 The block SHALL have port CLK100MHZ  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port CPU_RESETN  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port next_pulse  input  1  one-cycle debounced advance request.
REQ-005 The block SHALL have port back_pulse  input  1  one-cycle debounced step-back request.
REQ-006 The block SHALL have port chain_pulse  input  1  one-cycle debounced chain request (used only with ALU_CHAIN_EN).
REQ-007 The block SHALL have port sw  input  16  operand/opcode entry value.
REQ-008 The block SHALL have port alu_result  input  16  combinational ALU result for the current op1/op2/opcode.
REQ-009 The block SHALL have port alu_status  input  1  combinational ALU error flag.
REQ-010 The block SHALL have ports op1 and op2  output  16 each  registered operands driven to the ALU.
REQ-011 The block SHALL have port opcode  output  2  registered ALU operation select.
REQ-012 The block SHALL have port state  output  2  current stage: 0=S_OP1, 1=S_OP2, 2=S_OPC, 3=S_RES.
REQ-013 The block SHALL have port result_q  output  16  result captured on entry to S_RES.
REQ-014 The block SHALL have ports err, led_r and led_g  output  1 each  captured error flag, red indicator and green indicator.

Function
REQ-015 A cycle SHALL be a "valid request" only when exactly one of next_pulse, back_pulse and chain_pulse is high; two or more high in the same cycle SHALL cause no action.
REQ-016 In S_OP1, next_pulse SHALL load op1<=sw and move to S_OP2 on the same edge.
REQ-017 In S_OP2, next_pulse SHALL load op2<=sw and move to S_OPC.
REQ-018 In S_OPC, next_pulse SHALL load opcode<=sw[1:0] and move to S_RES.
REQ-019 On the first cycle in S_RES, the block SHALL capture result_q<=alu_result and err<=alu_status, so result_q and err become valid 2 cycles after the accepted next_pulse in S_OPC.
REQ-020 In S_RES, next_pulse SHALL move to S_OP1 and clear err; op1, op2, opcode and result_q SHALL be retained.
REQ-021 back_pulse SHALL step one stage back with no register change: S_OP2->S_OP1, S_OPC->S_OP2, S_RES->S_OPC (clearing err); in S_OP1 it SHALL be ignored.
REQ-022 In S_RES, an inactivity counter SHALL increment every cycle with no valid request, and SHALL clear on any state change or valid request.
REQ-023 When the inactivity counter reaches TIMEOUT_CYC-1 (TIMEOUT_CYC>0), the block SHALL move to S_OP1 and clear err; a request in that same cycle SHALL take precedence.
REQ-024 led_g SHALL equal (state==S_RES)&~err, and led_r SHALL equal (state==S_RES)&err, both combinational from registered values.
REQ-025 sw changes outside an accepted load edge SHALL NOT affect op1, op2 or opcode.

Reset
REQ-026 On CPU_RESETN low, the block SHALL asynchronously force state=S_OP1, op1=0, op2=0, opcode=0, result_q=0, err=0 and inactivity counter=0.
REQ-027 A reset mid-sequence SHALL discard the partial entry, and the first accepted next_pulse after release SHALL load op1.
REQ-028 Pulses coincident with the reset release edge SHALL be ignored.

Configuration
REQ-029 With macro ALU_CHAIN_EN defined, chain_pulse in S_RES SHALL load op1<=result_q, clear err and move to S_OP2, allowing accumulation; in other states chain_pulse SHALL be ignored.
REQ-030 Without ALU_CHAIN_EN, chain_pulse SHALL be ignored in all states, but SHALL still count toward the simultaneity rule of REQ-015, and the port SHALL remain present.

Verification
REQ-031 The bench SHALL drive sw=0x0005 then next, sw=0x0003 then next, sw=0x0000 (add) then next, and SHALL check op1=5, op2=3, opcode=0, state=3, result_q=0x0008 two cycles after the last pulse, led_g=1.
REQ-032 The bench SHALL drive alu_status=1 on S_RES entry and SHALL check err=1, led_r=1, led_g=0; it SHALL then apply back and check state=2, err=0, led_r=0.
REQ-033 The bench SHALL drive next and back in the same cycle in S_OP2 and SHALL check state stays 1 and op2 is unchanged.
REQ-034 The bench SHALL use TIMEOUT_CYC=10 and idle in S_RES, and SHALL check state=0 exactly 10 cycles after S_RES entry with op1/op2 retained; a next pulse on cycle 9 SHALL reset the count.
REQ-035 The bench SHALL apply CPU_RESETN low while in S_OPC and SHALL check all outputs zero immediately (asynchronously) and state=0 after release.
REQ-036 With ALU_CHAIN_EN defined and result_q=0x0008 in S_RES, the bench SHALL apply chain and check op1=0x0008 and state=1; without the macro, the same stimulus SHALL leave state=3.
